// File: rtl/rr_ex_stage.sv
// Register-read stage: 8x16 register file with writeback bypass, RR/EX pipeline
// register, and a one-bubble load-use interlock driving freeze upstream.
module rr_ex_stage #(
  parameter logic [3:0] LW_OPCODE = 4'b0100,
  parameter int         NREGS     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [15:0] pc_in,
  input  logic [15:0] pc2_in,
  input  logic [15:0] IR_in,
  input  logic [2:0]  alu_ctrl_in,
  input  logic        reg_wr_en_in,
  input  logic        mem_wr_en_in,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        freeze,
  output logic [15:0] pc_out,
  output logic [15:0] pc2_out,
  output logic [15:0] IR_out,
  output logic [15:0] ra_data_out,
  output logic [15:0] rb_data_out,
  output logic [2:0]  alu_ctrl_out,
  output logic        reg_wr_en_out,
  output logic        mem_wr_en_out,
  output logic        mem_rd_out,
  output logic        dbg_state_o
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [15:0] rf_q [NREGS];

  logic [15:0] pc_q, pc_d;
  logic [15:0] pc2_q, pc2_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ra_q, ra_d;
  logic [15:0] rb_q, rb_d;
  logic [2:0]  alu_q, alu_d;
  logic        rwe_q, rwe_d;
  logic        mwe_q, mwe_d;
  logic        mrd_q, mrd_d;

  logic [2:0]  ra_idx, rb_idx;
  logic [15:0] ra_rd, rb_rd;
  logic        haz;

  assign ra_idx = IR_in[11:9];
  assign rb_idx = IR_in[8:6];

  // Write-before-read: a same-cycle writeback to the read index wins over the array.
  assign ra_rd = (wb_en && (wb_addr == ra_idx)) ? wb_data : rf_q[ra_idx];
  assign rb_rd = (wb_en && (wb_addr == rb_idx)) ? wb_data : rf_q[rb_idx];

  assign haz    = mrd_q && rwe_q && ((ir_q[11:9] == ra_idx) || (ir_q[11:9] == rb_idx));
  assign freeze = (state_q == RUN) && haz && !br_taken;

  always_comb begin
    state_d = RUN;
    if (freeze) state_d = STALL;
  end

  always_comb begin
    pc_d  = pc_q;
    pc2_d = pc2_q;
    ir_d  = ir_q;
    ra_d  = ra_q;
    rb_d  = rb_q;
    alu_d = alu_q;
    rwe_d = 1'b0;
    mwe_d = 1'b0;
    mrd_d = 1'b0;
    if (freeze) begin
      // Bubble: kill the instruction, keep datapath fields unchanged.
      ir_d = 16'h0000;
    end else begin
      pc_d  = pc_in;
      pc2_d = pc2_in;
      ir_d  = IR_in;
      ra_d  = ra_rd;
      rb_d  = rb_rd;
      alu_d = alu_ctrl_in;
      rwe_d = reg_wr_en_in && !br_taken;
      mwe_d = mem_wr_en_in && !br_taken;
      mrd_d = (IR_in[15:12] == LW_OPCODE) && !br_taken;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= 16'h0000;
    end else if (wb_en) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= 16'h0000;
      pc2_q   <= 16'h0000;
      ir_q    <= 16'h0000;
      ra_q    <= 16'h0000;
      rb_q    <= 16'h0000;
      alu_q   <= 3'b000;
      rwe_q   <= 1'b0;
      mwe_q   <= 1'b0;
      mrd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc2_q   <= pc2_d;
      ir_q    <= ir_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      alu_q   <= alu_d;
      rwe_q   <= rwe_d;
      mwe_q   <= mwe_d;
      mrd_q   <= mrd_d;
    end
  end

  assign pc_out        = pc_q;
  assign pc2_out       = pc2_q;
  assign IR_out        = ir_q;
  assign ra_data_out   = ra_q;
  assign rb_data_out   = rb_q;
  assign alu_ctrl_out  = alu_q;
  assign reg_wr_en_out = rwe_q;
  assign mem_wr_en_out = mwe_q;
  assign mem_rd_out    = mrd_q;
  assign dbg_state_o   = state_q;

endmodule
